mlp_sequencer: RTL
==================

MLP_SEQUENCER -- requirements
Module: mlp_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, bit width of one signed Q8.8 activation.
REQ-002 Parameter VEC, default 16, number of activation lanes per packed BRAM word.
REQ-003 Parameter NUM_LAYERS, default 3, number of fully-connected layers to sequence.
REQ-004 Parameter OUT_DEPTH, default 10, number of final-layer outputs (classes).
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  begin one inference when sampled in IDLE.
REQ-008 busy  out  1  high from the cycle after start is accepted until the done cycle, inclusive.
REQ-009 done  out  1  one-cycle pulse when output_class and max_value are valid.
REQ-010 layer_start  out  NUM_LAYERS  one-hot, one-cycle pulse that launches layer i.
REQ-011 layer_done  in  NUM_LAYERS  pulse from layer i on completion.
REQ-012 rd_en  out  1  read strobe to the final-layer output BRAM.
REQ-013 rd_addr  out  max(1,$clog2(ceil(OUT_DEPTH/VEC)))  packed-word address.
REQ-014 rd_data  in  VEC*DATA_WIDTH  packed word; lane j is bits [j*DATA_WIDTH +: DATA_WIDTH]; valid one cycle after rd_en.
REQ-015 output_class  out  $clog2(OUT_DEPTH)  argmax index.
REQ-016 max_value  out  DATA_WIDTH  signed value at the argmax index.
REQ-017 perf_cycles  out  32  cycles from start acceptance to done, saturating at 2^32-1.

Function
REQ-018 The FSM SHALL use the states IDLE, L_START, L_WAIT, A_READ, A_SCAN and FINISH.
REQ-019 IDLE SHALL move to L_START with layer index 0 when start=1; start in any other state SHALL be ignored.
REQ-020 L_START SHALL assert layer_start[idx] for exactly one cycle, then go to L_WAIT.
REQ-021 L_WAIT SHALL respond only to layer_done[idx]: if idx<NUM_LAYERS-1, go to L_START with idx+1, otherwise go to A_READ; layer_done bits of other layers SHALL be ignored.
REQ-022 A layer_done asserted in the same cycle as its layer_start SHALL be ignored.
REQ-023 A_READ SHALL assert rd_en for one cycle with rd_addr=w, where w starts at 0, then go to A_SCAN.
REQ-024 A_SCAN SHALL capture rd_data on its first cycle and compare one lane per cycle (lane 0 first), covering global index w*VEC+j only while that index is < OUT_DEPTH.
REQ-025 The comparison SHALL be signed; the running max SHALL update only when the lane value is strictly greater, so ties resolve to the lowest index.
REQ-026 The running max SHALL initialise to 0x8000 with class 0 at A_READ of word 0.
REQ-027 After the last valid lane of a word, A_SCAN SHALL go to A_READ with w+1 if more indices remain, otherwise to FINISH.
REQ-028 FINISH SHALL pulse done for one cycle, register output_class, max_value and perf_cycles, then return to IDLE.
REQ-029 output_class, max_value and perf_cycles SHALL hold their values until the next done or reset.
REQ-030 Timing: last layer_done at cycle T gives rd_en at T+1 and lane compares at T+2 through T+1+OUT_DEPTH (OUT_DEPTH<=VEC); done is at T+2+OUT_DEPTH.
REQ-031 perf_cycles SHALL count 1 in the first cycle after start acceptance and include the done cycle.

Reset
REQ-032 rst SHALL force IDLE in any state, including mid-layer or mid-scan, and drop any inference in progress.
REQ-033 All outputs SHALL reset to 0: busy, done, layer_start, rd_en, rd_addr, output_class, max_value and perf_cycles.
REQ-034 A start asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-035 The shared package mlp_pkg SHALL hold the FSM state enum, the Q8.8 FRAC_BITS=8 constant and the lane-extract helper function.
REQ-036 The lane-serial signed comparator and running max/index registers SHALL be one sub-module, mlp_argmax; the FSM, counters and BRAM port SHALL stay in mlp_sequencer.

Verification
REQ-037 Start; respond to each layer_start with layer_done 5 cycles later; lane 3=0x0280 and all other lanes 0x0100 -> layer_start pulses in order 0,1,2; output_class=3; max_value=0x0280; done 12 cycles after the last layer_done.
REQ-038 All lanes negative, with lane 7=0xFF00 (-1.0) as the largest -> output_class=7; max_value=0xFF00.
REQ-039 Lanes 2 and 5 both 0x0400, all others lower -> output_class=2 (lowest index wins the tie).
REQ-040 Pulse layer_done[2] during layer 0's L_WAIT, and pulse start while busy -> both ignored; sequence order and perf_cycles are unchanged versus the baseline run.
REQ-041 Assert rst during layer 1's L_WAIT, then run a fresh inference -> all outputs 0 the cycle after reset; the second run produces the correct class and a perf_cycles value equal to the baseline.
REQ-042 With VEC=4 and OUT_DEPTH=10, put the maximum 0x0700 at index 9 -> 3 rd_en pulses at addresses 0, 1, 2; output_class=9.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared types and helpers for the MLP inference sequencer and its argmax unit.
package mlp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    L_START,
    L_WAIT,
    A_READ,
    A_SCAN,
    FINISH
  } state_t;

  localparam int FRAC_BITS  = 8;
  localparam int LANE_MAX_W = 4096;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Shifts lane `lane` of a packed word down to bit 0; caller truncates to dw bits.
  function automatic logic [LANE_MAX_W-1:0] lane_shift(input logic [LANE_MAX_W-1:0] word,
                                                       input int unsigned lane,
                                                       input int unsigned dw);
    return word >> (lane * dw);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mlp_argmax.sv
// Lane-serial signed argmax: one compare per enabled cycle, ties keep the lower index.
module mlp_argmax
  import mlp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CW         = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         init,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] lane_val,
  input  logic        [CW-1:0]         lane_idx,
  output logic signed [DATA_WIDTH-1:0] nxt_max,
  output logic        [CW-1:0]         nxt_idx
);

  logic signed [DATA_WIDTH-1:0] run_max_q, run_max_d;
  logic        [CW-1:0]         run_idx_q, run_idx_d;

  always_comb begin
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    if (init) begin
      run_max_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      run_idx_d = '0;
    end else if (en && (lane_val > run_max_q)) begin
      run_max_d = lane_val;
      run_idx_d = lane_idx;
    end
  end

  // The sequencer latches the post-compare values on the final lane, so expose them.
  assign nxt_max = run_max_d;
  assign nxt_idx = run_idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_max_q <= '0;
      run_idx_q <= '0;
    end else begin
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
    end
  end

endmodule

// File: rtl/mlp_sequencer.sv
// Launches NUM_LAYERS layers in order, then scans the final-layer BRAM for the argmax class.
module mlp_sequencer
  import mlp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int VEC        = 16,
  parameter int NUM_LAYERS = 3,
  parameter int OUT_DEPTH  = 10
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  output logic                                          busy,
  output logic                                          done,
  output logic [NUM_LAYERS-1:0]                         layer_start,
  input  logic [NUM_LAYERS-1:0]                         layer_done,
  output logic                                          rd_en,
  output logic [clog2_min1((OUT_DEPTH+VEC-1)/VEC)-1:0]  rd_addr,
  input  logic [VEC*DATA_WIDTH-1:0]                     rd_data,
  output logic [clog2_min1(OUT_DEPTH)-1:0]              output_class,
  output logic [DATA_WIDTH-1:0]                         max_value,
  output logic [31:0]                                   perf_cycles
);

  localparam int NWORDS = (OUT_DEPTH + VEC - 1) / VEC;
  localparam int AW     = clog2_min1(NWORDS);
  localparam int LW     = clog2_min1(VEC);
  localparam int IW     = clog2_min1(NUM_LAYERS);
  localparam int CW     = clog2_min1(OUT_DEPTH);

  state_t                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [AW-1:0]             w_q, w_d;
  logic [LW-1:0]             j_q, j_d;
  logic [VEC*DATA_WIDTH-1:0] word_q, word_d;
  logic [31:0]               cyc_q, cyc_d;
  logic [CW-1:0]             output_class_q, output_class_d;
  logic [DATA_WIDTH-1:0]     max_value_q, max_value_d;
  logic [31:0]               perf_q, perf_d;

  logic                         am_init, am_en;
  logic signed [DATA_WIDTH-1:0] lane_val;
  logic signed [DATA_WIDTH-1:0] am_max;
  logic        [CW-1:0]         am_idx;
  logic [VEC*DATA_WIDTH-1:0]    cur_word;
  logic [31:0]                  gidx;

  // Lane 0 is compared straight off the BRAM output; later lanes use the captured copy.
  assign cur_word = (j_q == '0) ? rd_data : word_q;
  assign lane_val = DATA_WIDTH'(lane_shift(LANE_MAX_W'(cur_word), 32'(j_q), DATA_WIDTH));
  assign gidx     = 32'(w_q) * 32'(VEC) + 32'(j_q);

  mlp_argmax #(
    .DATA_WIDTH(DATA_WIDTH),
    .CW        (CW)
  ) u_argmax (
    .clk     (clk),
    .rst     (rst),
    .init    (am_init),
    .en      (am_en),
    .lane_val(lane_val),
    .lane_idx(CW'(gidx)),
    .nxt_max (am_max),
    .nxt_idx (am_idx)
  );

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    w_d            = w_q;
    j_d            = j_q;
    word_d         = word_q;
    cyc_d          = cyc_q;
    output_class_d = output_class_q;
    max_value_d    = max_value_q;
    perf_d         = perf_q;
    am_init        = 1'b0;
    am_en          = 1'b0;
    if (state_q != IDLE) cyc_d = sat_inc32(cyc_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = L_START;
          idx_d   = '0;
          w_d     = '0;
          cyc_d   = 32'd1;
        end
      end
      L_START: state_d = L_WAIT;
      L_WAIT: begin
        if (layer_done[idx_q]) begin
          if (idx_q == IW'(NUM_LAYERS-1)) begin
            state_d = A_READ;
            w_d     = '0;
          end else begin
            state_d = L_START;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      A_READ: begin
        state_d = A_SCAN;
        j_d     = '0;
        am_init = (w_q == '0);
      end
      A_SCAN: begin
        am_en = 1'b1;
        j_d   = j_q + 1'b1;
        if (j_q == '0) word_d = rd_data;
        if (gidx == 32'(OUT_DEPTH-1)) begin
          state_d        = FINISH;
          output_class_d = am_idx;
          max_value_d    = am_max;
          perf_d         = sat_inc32(cyc_q);
        end else if (j_q == LW'(VEC-1)) begin
          state_d = A_READ;
          w_d     = w_q + 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      w_q            <= '0;
      j_q            <= '0;
      word_q         <= '0;
      cyc_q          <= '0;
      output_class_q <= '0;
      max_value_q    <= '0;
      perf_q         <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      w_q            <= w_d;
      j_q            <= j_d;
      word_q         <= word_d;
      cyc_q          <= cyc_d;
      output_class_q <= output_class_d;
      max_value_q    <= max_value_d;
      perf_q         <= perf_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FINISH);
  assign rd_en        = (state_q == A_READ);
  assign rd_addr      = w_q;
  assign layer_start  = (state_q == L_START) ? (NUM_LAYERS'(1) << idx_q) : '0;
  assign output_class = output_class_q;
  assign max_value    = max_value_q;
  assign perf_cycles  = perf_q;

endmodule
